// File: rtl/xcr_pkg.sv
// Shared definitions for the XCR interrupt entry/return sequencer.
// Holds the sequencer state encoding, the MCAUS field layout and the vector
// arithmetic helpers. The vector helpers are used by xcr_int_sched.
package xcr_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StReq    = 2'd1,
        StActive = 2'd2
    } xcr_state_e;

    // MCAUS layout: {is_int, reserved 0, idx[2:0]}
    localparam int unsigned McausW        = 5;
    localparam int unsigned McausIsIntBit = 4;
    localparam int unsigned McausIdxLsb   = 0;
    localparam int unsigned McausIdxW     = 3;

    // IVT entry size is 4 << ivesiz bytes, so the code shifts by 2 + ivesiz
    localparam int unsigned IvesizShiftBase = 2;

    // Largest offset is 15 << 5 = 480
    localparam int unsigned OffsetW = 9;

    function automatic logic [McausW-1:0] mcaus_pack(input logic is_int,
                                                     input logic [McausIdxW-1:0] idx);
        logic [McausW-1:0] m;
        m = '0;
        m[McausIsIntBit] = is_int;
        m[McausIdxLsb +: McausIdxW] = idx;
        return m;
    endfunction

    function automatic logic [OffsetW-1:0] vec_offset(input logic is_int,
                                                      input logic [2:0] idx,
                                                      input logic [1:0] ivesiz);
        logic [OffsetW-1:0] code;
        code = {5'b0, is_int, idx};
        return code << (IvesizShiftBase + ivesiz);
    endfunction

endpackage

// File: rtl/xcr_int_sched_if.sv
// Bundle between the interrupt controller / CPU core and the sequencer.
// master: the sequencer (xcr_int_sched).
// slave : the controller + core side (pending regs, int_ack, irq_ret).
// Signals:
//   int_en, ivesiz, ivt_base   controller configuration
//   xcp_pend, int_pend         pending bits from XCPP0 / INTP0
//   int_req, int_ack, irq_ret  trap handshake with the core
//   ivec_addr, mcaus           handler address and cause
//   xcp_clr, int_clr           one-cycle w1c pulses to the pending regs
//   in_handler                 handler occupancy
interface xcr_int_sched_if #(
    parameter int unsigned NSRC = 8,
    parameter int unsigned AW   = 24
);
    logic            int_en;
    logic [1:0]      ivesiz;
    logic [AW-1:0]   ivt_base;
    logic [NSRC-1:0] xcp_pend;
    logic [NSRC-1:0] int_pend;
    logic            int_req;
    logic            int_ack;
    logic            irq_ret;
    logic [AW-1:0]   ivec_addr;
    logic [4:0]      mcaus;
    logic [NSRC-1:0] xcp_clr;
    logic [NSRC-1:0] int_clr;
    logic            in_handler;

    modport master (
        input  int_en, ivesiz, ivt_base, xcp_pend, int_pend, int_ack, irq_ret,
        output int_req, ivec_addr, mcaus, xcp_clr, int_clr, in_handler
    );

    modport slave (
        output int_en, ivesiz, ivt_base, xcp_pend, int_pend, int_ack, irq_ret,
        input  int_req, ivec_addr, mcaus, xcp_clr, int_clr, in_handler
    );
endinterface

// File: rtl/xcr_prio_enc.sv
// Fixed-priority encoder over the exception and interrupt pending groups.
// Any exception beats any interrupt; within a group the lowest index wins.
// Ports:
//   xcp_pend, int_pend  pending bit groups (NSRC wide each)
//   valid               any bit pending
//   is_int              winner is from the interrupt group
//   idx                 winner's index within its group
module xcr_prio_enc #(
    parameter int unsigned NSRC = 8
) (
    input  logic [NSRC-1:0] xcp_pend,
    input  logic [NSRC-1:0] int_pend,
    output logic            valid,
    output logic            is_int,
    output logic [2:0]      idx
);

    always_comb begin
        valid  = 1'b0;
        is_int = 1'b0;
        idx    = '0;
        // Scan high to low so the lowest set index is the last to write;
        // the exception pass runs second so it overrides any interrupt.
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (int_pend[i]) begin
                valid  = 1'b1;
                is_int = 1'b1;
                idx    = 3'(i);
            end
        end
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (xcp_pend[i]) begin
                valid  = 1'b1;
                is_int = 1'b0;
                idx    = 3'(i);
            end
        end
    end

endmodule

// File: rtl/xcr_int_sched.sv
// Interrupt entry/return sequencer. Picks the highest-priority pending source,
// latches its cause and vector, runs the int_req/int_ack handshake with the
// core, pulses the matching w1c clear bit once on acceptance and then holds
// in_handler until irq_ret. No nesting: selection only happens in idle.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   bus       xcr_int_sched_if master modport (config, pending bits,
//             handshake, vector/cause, clear pulses, occupancy)
module xcr_int_sched
    import xcr_pkg::*;
#(
    parameter int unsigned NSRC = 8,
    parameter int unsigned AW   = 24
) (
    input logic             clk,
    input logic             rst,
    xcr_int_sched_if.master bus
);

    logic enc_valid;
    logic enc_is_int;
    logic [2:0] enc_idx;

    xcr_prio_enc #(
        .NSRC (NSRC)
    ) u_prio_enc (
        .xcp_pend (bus.xcp_pend),
        .int_pend (bus.int_pend),
        .valid    (enc_valid),
        .is_int   (enc_is_int),
        .idx      (enc_idx)
    );

    xcr_state_e      state_q, state_d;
    logic            is_int_q, is_int_d;
    logic [2:0]      idx_q, idx_d;
    logic [4:0]      mcaus_q, mcaus_d;
    logic [AW-1:0]   ivec_q, ivec_d;
    logic [NSRC-1:0] xcp_clr_q, xcp_clr_d;
    logic [NSRC-1:0] int_clr_q, int_clr_d;

    // Widen pending groups to 8 so the 3-bit latched index is always in range
    logic [7:0] xcp_pend8;
    logic [7:0] int_pend8;
    logic       latched_pend;
    logic [7:0] sel_onehot;

    assign xcp_pend8    = 8'(bus.xcp_pend);
    assign int_pend8    = 8'(bus.int_pend);
    assign latched_pend = is_int_q ? int_pend8[idx_q] : xcp_pend8[idx_q];
    assign sel_onehot   = 8'b1 << idx_q;

    always_comb begin
        state_d   = state_q;
        is_int_d  = is_int_q;
        idx_d     = idx_q;
        mcaus_d   = mcaus_q;
        ivec_d    = ivec_q;
        xcp_clr_d = '0;
        int_clr_d = '0;

        unique case (state_q)
            StIdle: begin
                if (bus.int_en && enc_valid) begin
                    state_d  = StReq;
                    is_int_d = enc_is_int;
                    idx_d    = enc_idx;
                    mcaus_d  = mcaus_pack(enc_is_int, enc_idx);
                    // Zero-extended add; wrap past 2^AW is intentionally silent
                    ivec_d   = bus.ivt_base + AW'(vec_offset(enc_is_int, enc_idx, bus.ivesiz));
                end
            end
            StReq: begin
                // Ack takes precedence over any withdraw condition
                if (bus.int_ack) begin
                    state_d = StActive;
                    if (is_int_q) begin
                        int_clr_d = sel_onehot[NSRC-1:0];
                    end else begin
                        xcp_clr_d = sel_onehot[NSRC-1:0];
                    end
                end else if (!bus.int_en || !latched_pend) begin
                    state_d = StIdle;
                end
            end
            StActive: begin
                if (bus.irq_ret) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            is_int_q  <= 1'b0;
            idx_q     <= '0;
            mcaus_q   <= '0;
            ivec_q    <= '0;
            xcp_clr_q <= '0;
            int_clr_q <= '0;
        end else begin
            state_q   <= state_d;
            is_int_q  <= is_int_d;
            idx_q     <= idx_d;
            mcaus_q   <= mcaus_d;
            ivec_q    <= ivec_d;
            xcp_clr_q <= xcp_clr_d;
            int_clr_q <= int_clr_d;
        end
    end

    assign bus.int_req    = (state_q == StReq);
    assign bus.in_handler = (state_q == StActive);
    assign bus.mcaus      = mcaus_q;
    assign bus.ivec_addr  = ivec_q;
    assign bus.xcp_clr    = xcp_clr_q;
    assign bus.int_clr    = int_clr_q;

endmodule

// File: tb/tb_xcr_int_sched.sv
// Directed bench for xcr_int_sched. Expected cause/vector/clear values are
// pushed to a scoreboard when a source is raised and popped when the DUT
// requests the trap.
module tb_xcr_int_sched;

    localparam int unsigned NSRC = 8;
    localparam int unsigned AW   = 24;

    typedef struct packed {
        logic [4:0]  mcaus;
        logic [23:0] ivec;
        logic [7:0]  xclr;
        logic [7:0]  iclr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    xcr_int_sched_if #(.NSRC(NSRC), .AW(AW)) bus ();

    xcr_int_sched #(
        .NSRC (NSRC),
        .AW   (AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int total = 0;
    int bad   = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_req"},  32'(bus.int_req), 0);
        chk({tag, "_inh"},  32'(bus.in_handler), 0);
        chk({tag, "_xclr"}, 32'(bus.xcp_clr), 0);
        chk({tag, "_iclr"}, 32'(bus.int_clr), 0);
        chk({tag, "_caus"}, 32'(bus.mcaus), 0);
        chk({tag, "_vec"},  32'(bus.ivec_addr), 0);
    endtask

    // Pop the expected trap, check cause/vector, ack it and check the clear pulse.
    task automatic service(input string tag, input bit drop_en);
        exp_t e;
        if (exp_q.size() == 0) begin
            $display("FAIL %s: scoreboard empty", tag);
            $fatal(1);
        end
        e = exp_q.pop_front();
        chk({tag, "_caus"}, 32'(bus.mcaus), 32'(e.mcaus));
        chk({tag, "_vec"},  32'(bus.ivec_addr), 32'(e.ivec));
        bus.int_ack = 1'b1;
        if (drop_en) bus.int_en = 1'b0;
        step();
        bus.int_ack = 1'b0;
        bus.int_en  = 1'b1;
        chk({tag, "_ack_req"}, 32'(bus.int_req), 0);
        chk({tag, "_ack_inh"}, 32'(bus.in_handler), 1);
        chk({tag, "_xclr"}, 32'(bus.xcp_clr), 32'(e.xclr));
        chk({tag, "_iclr"}, 32'(bus.int_clr), 32'(e.iclr));
        // Controller clears the acknowledged bit
        bus.xcp_pend = bus.xcp_pend & ~e.xclr;
        bus.int_pend = bus.int_pend & ~e.iclr;
        step();
        chk({tag, "_xclr_1cy"}, 32'(bus.xcp_clr), 0);
        chk({tag, "_iclr_1cy"}, 32'(bus.int_clr), 0);
        chk({tag, "_inh_hold"}, 32'(bus.in_handler), 1);
    endtask

    task automatic do_ret(input string tag);
        bus.irq_ret = 1'b1;
        step();
        bus.irq_ret = 1'b0;
        chk({tag, "_inh"}, 32'(bus.in_handler), 0);
        chk({tag, "_req"}, 32'(bus.int_req), 0);
    endtask

    task automatic wait_req(input string tag, input int budget);
        int n = 0;
        while (bus.int_req !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk(tag, 32'(bus.int_req), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.int_en   = 1'b0;
        bus.ivesiz   = 2'd0;
        bus.ivt_base = '0;
        bus.xcp_pend = '0;
        bus.int_pend = '0;
        bus.int_ack  = 1'b0;
        bus.irq_ret  = 1'b0;
        rst = 1'b1;
        step();
        step();
        chk_reset_outs("reset");
        rst = 1'b0;

        // Basic interrupt entry, one-cycle latency
        bus.ivt_base = 24'h001000;
        bus.ivesiz   = 2'd0;
        bus.int_en   = 1'b1;
        bus.int_pend = 8'h04;
        exp_q.push_back('{mcaus: 5'h12, ivec: 24'h001028, xclr: 8'h00, iclr: 8'h04});
        step();
        chk("basic_latency", 32'(bus.int_req), 1);
        service("basic", 1'b0);
        do_ret("basic_ret");

        // Exception beats interrupt; interrupt waits until after return
        bus.ivesiz   = 2'd3;
        bus.ivt_base = 24'h000200;
        bus.xcp_pend = 8'h80;
        bus.int_pend = 8'h01;
        exp_q.push_back('{mcaus: 5'h07, ivec: 24'h0002E0, xclr: 8'h80, iclr: 8'h00});
        exp_q.push_back('{mcaus: 5'h10, ivec: 24'h000300, xclr: 8'h00, iclr: 8'h01});
        step();
        chk("xcp_req", 32'(bus.int_req), 1);
        service("xcp", 1'b0);
        step();
        chk("nonest_req", 32'(bus.int_req), 0);
        chk("nonest_inh", 32'(bus.in_handler), 1);
        do_ret("nonest_ret");
        step();
        chk("ret_2cy_req", 32'(bus.int_req), 1);
        service("after_ret", 1'b0);
        do_ret("after_ret_ret");

        // No re-selection in REQ, then withdraw by clearing the latched bit
        bus.ivesiz   = 2'd0;
        bus.ivt_base = 24'h001000;
        bus.int_pend = 8'h02;
        step();
        chk("wd_clr_req", 32'(bus.int_req), 1);
        bus.xcp_pend = 8'h01;
        step();
        chk("noresel_caus", 32'(bus.mcaus), 32'h11);
        chk("noresel_vec", 32'(bus.ivec_addr), 32'h001024);
        bus.int_pend = 8'h00;
        step();
        chk("wd_clr_req0", 32'(bus.int_req), 0);
        chk("wd_clr_iclr", 32'(bus.int_clr), 0);
        chk("wd_clr_xclr", 32'(bus.xcp_clr), 0);
        exp_q.push_back('{mcaus: 5'h00, ivec: 24'h001000, xclr: 8'h01, iclr: 8'h00});
        wait_req("wd_clr_reselect", 4);
        service("xcp0", 1'b0);
        do_ret("xcp0_ret");

        // Withdraw by dropping int_en
        bus.int_pend = 8'h02;
        step();
        chk("wd_en_req", 32'(bus.int_req), 1);
        bus.int_en = 1'b0;
        step();
        chk("wd_en_req0", 32'(bus.int_req), 0);
        chk("wd_en_iclr", 32'(bus.int_clr), 0);
        chk("wd_en_inh", 32'(bus.in_handler), 0);
        step();
        chk("wd_en_stay", 32'(bus.int_req), 0);
        bus.int_pend = 8'h00;
        bus.int_en   = 1'b1;
        step();
        chk("wd_en_idle", 32'(bus.int_req), 0);

        // Vector wrap; ack coincident with int_en falling is taken
        bus.ivt_base = 24'hFFFFF0;
        bus.ivesiz   = 2'd1;
        bus.int_pend = 8'h02;
        exp_q.push_back('{mcaus: 5'h11, ivec: 24'h000038, xclr: 8'h00, iclr: 8'h02});
        step();
        chk("wrap_req", 32'(bus.int_req), 1);
        service("wrap_ack_vs_en", 1'b1);

        // Stray ack in ACTIVE is ignored
        bus.int_ack = 1'b1;
        step();
        bus.int_ack = 1'b0;
        chk("stray_ack_inh", 32'(bus.in_handler), 1);
        chk("stray_ack_iclr", 32'(bus.int_clr), 0);

        // Reset while ACTIVE
        rst = 1'b1;
        step();
        chk_reset_outs("rst_active");
        rst = 1'b0;

        // Stray return in IDLE is ignored
        bus.irq_ret = 1'b1;
        step();
        bus.irq_ret = 1'b0;
        chk("stray_ret_inh", 32'(bus.in_handler), 0);
        chk("stray_ret_req", 32'(bus.int_req), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
